pcs_gearbox_rx: RTL and testbench



---
 rtl/pcs_pkg.sv | 11 +
 rtl/gearbox_rx_shift.sv | 40 ++++
 rtl/pcs_gearbox_rx.sv | 91 +++++++++
 tb/tb_pcs_gearbox_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared constants for the 10GBASE-R receive gearbox.
package pcs_pkg;

  localparam int unsigned HEAD_W  = 2;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BLOCK_W = 66;
  // Worst case pending bits: 65 left over plus one new 64-bit word.
  localparam int unsigned BUF_W   = 130;
  localparam int unsigned CNT_W   = 8;

endpackage

// File: rtl/gearbox_rx_shift.sv
// Combinational barrel shifter: appends a word at offset cnt, applies an
// optional one-bit slip and removes one block when enough bits are pending.
module gearbox_rx_shift
  import pcs_pkg::*;
#(
  parameter int unsigned SH_BUF_W = BUF_W,
  parameter int unsigned SH_CNT_W = CNT_W,
  parameter int unsigned SH_IN_W  = DATA_W,
  parameter int unsigned SH_BLK_W = BLOCK_W
) (
  input  logic [SH_BUF_W-1:0] i_buf,
  input  logic [SH_CNT_W-1:0] i_cnt,
  input  logic [SH_IN_W-1:0]  i_data,
  input  logic                i_slip,
  output logic                o_blk_v_c,
  output logic [SH_BLK_W-1:0] o_blk_c,
  output logic [SH_BUF_W-1:0] o_buf_c,
  output logic [SH_CNT_W-1:0] o_cnt_c
);

  logic [SH_BUF_W-1:0] w_ins;
  logic [SH_BUF_W-1:0] w_sh;
  logic [SH_CNT_W-1:0] w_cnt_app;

  // Bits above i_cnt in i_buf are always zero, so OR-ing inserts the word.
  always_comb begin
    w_ins     = i_buf | (SH_BUF_W'(i_data) << i_cnt);
    w_sh      = w_ins >> i_slip;
    w_cnt_app = i_cnt + SH_CNT_W'(SH_IN_W) - SH_CNT_W'(i_slip);
    o_blk_v_c = (w_cnt_app >= SH_CNT_W'(SH_BLK_W));
    o_blk_c   = w_sh[SH_BLK_W-1:0];
    o_buf_c   = w_sh;
    o_cnt_c   = w_cnt_app;
    if (o_blk_v_c) begin
      o_buf_c = w_sh >> SH_BLK_W;
      o_cnt_c = w_cnt_app - SH_CNT_W'(SH_BLK_W);
    end
  end

endmodule

// File: rtl/pcs_gearbox_rx.sv
// Receive 64b->66b gearbox with bit-slip for block-lock hunting.
// Define GEARBOX_RX_ASSERT_EN to include internal SVA checks.
module pcs_gearbox_rx #(
  parameter int unsigned HEAD_W = pcs_pkg::HEAD_W,
  parameter int unsigned DATA_W = pcs_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              lock_v_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              slip_v_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned BLK_W = HEAD_W + DATA_W;
  localparam int unsigned BUF_W = pcs_pkg::BUF_W;
  localparam int unsigned CNT_W = pcs_pkg::CNT_W;

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_blk_v;
  logic [BLK_W-1:0] w_blk;

  gearbox_rx_shift #(
    .SH_BUF_W (BUF_W),
    .SH_CNT_W (CNT_W),
    .SH_IN_W  (DATA_W),
    .SH_BLK_W (BLK_W)
  ) u_shift (
    .i_buf     (r_buf),
    .i_cnt     (r_cnt),
    .i_data    (data_i),
    .i_slip    (slip_v_i),
    .o_blk_v_c (w_blk_v),
    .o_blk_c   (w_blk),
    .o_buf_c   (w_buf_nxt),
    .o_cnt_c   (w_cnt_nxt)
  );

  // Loss of lock flushes pending bits; header/payload hold between blocks.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
      data_o  <= '0;
    end else if (!lock_v_i) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      valid_o <= 1'b0;
    end else begin
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      valid_o <= w_blk_v;
      if (w_blk_v) begin
        head_o <= w_blk[HEAD_W-1:0];
        data_o <= w_blk[BLK_W-1:HEAD_W];
      end
    end
  end

`ifdef GEARBOX_RX_ASSERT_EN
  logic [1:0] r_gap;

  // Consecutive locked, slip-free cycles without a block.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_gap <= 2'd0;
    end else if (!lock_v_i || slip_v_i || w_blk_v) begin
      r_gap <= 2'd0;
    end else if (r_gap != 2'd3) begin
      r_gap <= r_gap + 2'd1;
    end
  end

  a_occupancy : assert property (@(posedge clk) disable iff (!nreset)
    (32'(r_cnt) + 32'(DATA_W) <= 32'(BUF_W) - 32'd1));
  a_valid_known : assert property (@(posedge clk) disable iff (!nreset)
    !$isunknown(valid_o));
  a_data_known : assert property (@(posedge clk) disable iff (!nreset)
    valid_o |-> !$isunknown({head_o, data_o}));
  a_no_double_gap : assert property (@(posedge clk) disable iff (!nreset)
    r_gap < 2'd2);
`endif

endmodule

// File: tb/tb_pcs_gearbox_rx.sv
// Directed bench for pcs_gearbox_rx with a bit-queue reference model.
module tb_pcs_gearbox_rx;

  logic        clk = 1'b0;
  logic        nreset;
  logic        lock_v_i;
  logic [63:0] data_i;
  logic        slip_v_i;
  logic        valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;

  always #5 clk = ~clk;

  pcs_gearbox_rx dut (
    .clk      (clk),
    .nreset   (nreset),
    .lock_v_i (lock_v_i),
    .data_i   (data_i),
    .slip_v_i (slip_v_i),
    .valid_o  (valid_o),
    .head_o   (head_o),
    .data_o   (data_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          mq[$];
  logic        m_v;
  logic [1:0]  m_h;
  logic [63:0] m_d;

  bit          src[$];
  logic [63:0] pay[$];
  int          k;
  int          nv;
  logic [63:0] w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serial bit-stream reference: append, slip, then pop one block if available.
  task automatic model(input logic lk, input logic [63:0] d, input logic sl);
    logic [65:0] b;
    if (!lk) begin
      mq.delete();
      m_v = 1'b0;
      return;
    end
    for (int i = 0; i < 64; i++) mq.push_back(d[i]);
    if (sl) void'(mq.pop_front());
    if (mq.size() >= 66) begin
      for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
      m_v = 1'b1;
      m_h = b[1:0];
      m_d = b[65:2];
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic cyc(input string tag, input logic lk, input logic [63:0] d, input logic sl);
    lock_v_i = lk;
    data_i   = d;
    slip_v_i = sl;
    model(lk, d, sl);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 64'(valid_o), 64'(m_v));
    chk({tag, ".head"},  64'(head_o),  64'(m_h));
    chk({tag, ".data"},  data_o,       m_d);
  endtask

  // Serialiser of framed 66b blocks (header 2'b01) into 64b words.
  task automatic src_word(output logic [63:0] wo);
    logic [63:0] p;
    while (src.size() < 64) begin
      p = {$urandom(), $urandom()};
      pay.push_back(p);
      src.push_back(1'b1);
      src.push_back(1'b0);
      for (int i = 0; i < 64; i++) src.push_back(p[i]);
    end
    for (int i = 0; i < 64; i++) wo[i] = src.pop_front();
  endtask

  initial begin
    nreset = 1'b0; lock_v_i = 1'b0; slip_v_i = 1'b0; data_i = '0;
    m_v = 1'b0; m_h = '0; m_d = '0;

    // Reset state
    #12;
    chk("rst.valid", 64'(valid_o), 64'd0);
    chk("rst.head",  64'(head_o),  64'd0);
    chk("rst.data",  data_o,       64'd0);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("idle", 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0);

    // Cadence: 0, 32 x 1, 0, 32 x 1, 0, ...
    for (int i = 0; i < 99; i++) begin
      cyc("cad", 1'b1, {$urandom(), $urandom()}, 1'b0);
      chk("cad.pattern", 64'(valid_o), (i == 0 || i == 33 || i == 66) ? 64'd0 : 64'd1);
      if (!(i == 0 || i == 33 || i == 66))
        chk("cad.known", 64'($isunknown({head_o, data_o})), 64'd0);
    end

    // Constant 64'h27 pattern, hand-computed first block
    cyc("flush", 1'b0, 64'h0, 1'b0);
    cyc("k0", 1'b1, 64'h27, 1'b0);
    chk("k0.valid", 64'(valid_o), 64'd0);
    cyc("k1", 1'b1, 64'h27, 1'b0);
    chk("k1.valid", 64'(valid_o), 64'd1);
    chk("k1.head",  64'(head_o),  64'd3);
    chk("k1.data",  data_o,       64'hC000_0000_0000_0009);

    // Framed stream, aligned from the first word
    cyc("flush", 1'b0, 64'h0, 1'b0);
    src.delete(); pay.delete(); k = 0;
    for (int i = 0; i < 40; i++) begin
      src_word(w);
      cyc("frm", 1'b1, w, 1'b0);
      if (m_v) begin
        chk("frm.head", 64'(head_o), 64'd1);
        chk("frm.pay",  data_o, pay[k]);
        k++;
      end
    end

    // One slip: block bit 0 is now the header's bit 1 (always 0)
    for (int i = 0; i < 6; i++) begin
      src_word(w);
      cyc("slip1", 1'b1, w, (i == 0) ? 1'b1 : 1'b0);
      if (m_v) chk("slip1.head0", 64'(head_o[0]), 64'd0);
    end

    // 65 more slips wrap the phase back to block alignment
    for (int i = 0; i < 65; i++) begin
      src_word(w);
      cyc("slipn", 1'b1, w, 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      src_word(w);
      cyc("realign", 1'b1, w, 1'b0);
      if (m_v) chk("realign.head", 64'(head_o), 64'd1);
    end

    // Lock loss for 3 cycles, restart aligned to first post-lock word
    for (int i = 0; i < 3; i++) begin
      cyc("drop", 1'b0, {$urandom(), $urandom()}, 1'b1);
      chk("drop.valid", 64'(valid_o), 64'd0);
    end
    src.delete(); pay.delete(); k = 0; nv = 0;
    src_word(w);
    cyc("relock", 1'b1, w, 1'b0);
    chk("relock.valid", 64'(valid_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      src_word(w);
      cyc("relock.run", 1'b1, w, 1'b0);
      nv += int'(valid_o === 1'b1);
      chk("relock.head", 64'(head_o), 64'd1);
      chk("relock.pay",  data_o, pay[i]);
    end
    chk("relock.count", 64'(nv), 64'd10);

    // Asynchronous reset between edges
    for (int i = 0; i < 5; i++) cyc("pre", 1'b1, {$urandom(), $urandom()}, 1'b0);
    #4;
    nreset = 1'b0;
    #1;
    chk("arst.valid", 64'(valid_o), 64'd0);
    chk("arst.head",  64'(head_o),  64'd0);
    chk("arst.data",  data_o,       64'd0);
    mq.delete(); m_v = 1'b0; m_h = '0; m_d = '0;
    @(posedge clk);
    #1;
    chk("arst.hold", 64'(valid_o), 64'd0);
    nreset = 1'b1;
    for (int i = 0; i < 34; i++) begin
      cyc("arst.cad", 1'b1, {$urandom(), $urandom()}, 1'b0);
      chk("arst.pattern", 64'(valid_o), (i == 0 || i == 33) ? 64'd0 : 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
